// File: rtl/jk_excitation_gen.sv
// Buffers requested q values and drives a JK flop with the matching excitation,
// then checks the flop's q one cycle later and counts transitions and mismatches.
module jk_excitation_gen #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned DC_POLICY = 0,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    output logic [1:0]       jk,
    input  logic             q_fb,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned      AW      = $clog2(DEPTH);
    localparam logic [AW:0]      FullCnt = (AW+1)'(DEPTH);
    localparam logic [AW:0]      PtrOne  = (AW+1)'(1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic             Dc      = (DC_POLICY != 0);

    typedef enum logic [1:0] {StIdle, StApply, StCheck} state_e;

    state_e           state_q, state_d;
    logic [DEPTH-1:0] mem_q;
    logic [AW:0]      wptr_q, rptr_q, count;
    logic             empty, full, push, pop, head;
    logic             tgt_q, tgt_d, q_model_q, q_model_d, err_q, err_d;
    logic [1:0]       jk_q, jk_d;
    logic [CNT_W-1:0] xfer_q, xfer_d, errc_q, errc_d;

    // J is a don't-care when leaving 1, K is a don't-care when leaving 0.
    function automatic logic [1:0] excite(input logic q, input logic t);
        return q ? {Dc, ~t} : {t, Dc};
    endfunction

    assign count     = wptr_q - rptr_q;
    assign empty     = (count == '0);
    assign full      = (count == FullCnt);
    assign head      = mem_q[rptr_q[AW-1:0]];
    // A pop in this cycle frees a slot, so a full FIFO may still accept.
    assign tgt_ready = !full || pop;
    assign push      = tgt_valid && tgt_ready;

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        jk_d      = 2'b00;
        tgt_d     = tgt_q;
        q_model_d = q_model_q;
        err_d     = err_q;
        xfer_d    = xfer_q;
        errc_d    = errc_q;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    tgt_d   = head;
                    jk_d    = excite(q_model_q, head);
                    state_d = StApply;
                end
            end
            StApply: begin
                state_d = StCheck;
            end
            StCheck: begin
                xfer_d = xfer_q + CntOne;
                if (q_fb == tgt_q) begin
                    q_model_d = tgt_q;
                end else begin
                    q_model_d = q_fb;
                    err_d     = 1'b1;
                    if (errc_q != '1) begin
                        errc_d = errc_q + CntOne;
                    end
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            wptr_q    <= '0;
            rptr_q    <= '0;
            tgt_q     <= 1'b0;
            q_model_q <= 1'b0;
            err_q     <= 1'b0;
            jk_q      <= 2'b00;
            xfer_q    <= '0;
            errc_q    <= '0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            q_model_q <= q_model_d;
            err_q     <= err_d;
            jk_q      <= jk_d;
            xfer_q    <= xfer_d;
            errc_q    <= errc_d;
            if (push) begin
                wptr_q <= wptr_q + PtrOne;
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= tgt_bit;
        end
    end

    assign jk       = jk_q;
    assign err      = err_q;
    assign busy     = (state_q != StIdle) || !empty;
    assign xfer_cnt = xfer_q;
    assign err_cnt  = errc_q;

endmodule

// File: tb/tb_jk_excitation_gen.sv
// Bench for jk_excitation_gen: two instances (both don't-care policies), each driving
// its own JK flop model, checked against a queue-based reference model plus directed cases.
module tb_jk_excitation_gen;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tgt_valid = 1'b0;
    logic tgt_bit = 1'b0;
    logic force_en = 1'b0;
    logic force_val = 1'b0;

    logic             ready0, ready1, busy0, busy1, err0, err1;
    logic [1:0]       jk0, jk1;
    logic [CNT_W-1:0] xfer0, xfer1, errc0, errc1;
    logic             fq0, fq1, q_fb0, q_fb1;

    always #5 clk = ~clk;

    jk_excitation_gen #(.DEPTH(DEPTH), .DC_POLICY(0), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(ready0),
        .jk(jk0), .q_fb(q_fb0), .busy(busy0), .err(err0), .xfer_cnt(xfer0), .err_cnt(errc0)
    );

    jk_excitation_gen #(.DEPTH(DEPTH), .DC_POLICY(1), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit), .tgt_ready(ready1),
        .jk(jk1), .q_fb(q_fb1), .busy(busy1), .err(err1), .xfer_cnt(xfer1), .err_cnt(errc1)
    );

    // JK flop models: 00 hold, 01 reset, 10 set, 11 toggle.
    always @(posedge clk) begin
        if (rst) begin
            fq0 <= 1'b0;
            fq1 <= 1'b0;
        end else begin
            case (jk0)
                2'b01:   fq0 <= 1'b0;
                2'b10:   fq0 <= 1'b1;
                2'b11:   fq0 <= ~fq0;
                default: fq0 <= fq0;
            endcase
            case (jk1)
                2'b01:   fq1 <= 1'b0;
                2'b10:   fq1 <= 1'b1;
                2'b11:   fq1 <= ~fq1;
                default: fq1 <= fq1;
            endcase
        end
    end

    assign q_fb0 = force_en ? force_val : fq0;
    assign q_fb1 = force_en ? force_val : fq1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: queue of pending targets, transaction phase, per-instance beliefs.
    logic [1:0] tab [2][4];
    bit         mq[$];
    int         phase = 0;
    bit         cur = 1'b0;
    bit         qm [2];
    bit         errm [2];
    int         ec [2];
    int         xf = 0;
    bit         chk_en = 1'b0;

    function automatic bit m_ready();
        return (mq.size() < DEPTH) || (phase == 0 && mq.size() > 0);
    endfunction

    function automatic logic [1:0] m_jk(input int d);
        return (phase == 1) ? tab[d][2*int'(qm[d]) + int'(cur)] : 2'b00;
    endfunction

    task automatic model_check();
        if (!chk_en) return;
        check("m_jk0", 32'(jk0), 32'(m_jk(0)));
        check("m_jk1", 32'(jk1), 32'(m_jk(1)));
        check("m_ready0", 32'(ready0), 32'(m_ready()));
        check("m_ready1", 32'(ready1), 32'(m_ready()));
        check("m_busy0", 32'(busy0), 32'(phase != 0 || mq.size() > 0));
        check("m_busy1", 32'(busy1), 32'(phase != 0 || mq.size() > 0));
        check("m_err0", 32'(err0), 32'(errm[0]));
        check("m_err1", 32'(err1), 32'(errm[1]));
        check("m_xfer0", 32'(xfer0), 32'(xf % 256));
        check("m_xfer1", 32'(xfer1), 32'(xf % 256));
        check("m_errc0", 32'(errc0), 32'(ec[0]));
        check("m_errc1", 32'(errc1), 32'(ec[1]));
    endtask

    task automatic model_step();
        bit acc;
        bit obs;
        if (rst) begin
            mq.delete();
            phase = 0;
            xf = 0;
            for (int d = 0; d < 2; d++) begin
                qm[d] = 1'b0;
                errm[d] = 1'b0;
                ec[d] = 0;
            end
            chk_en = 1'b1;
            return;
        end
        acc = tgt_valid && m_ready();
        case (phase)
            0: if (mq.size() > 0) begin
                cur = mq.pop_front();
                phase = 1;
            end
            1: phase = 2;
            default: begin
                for (int d = 0; d < 2; d++) begin
                    obs = (d == 0) ? q_fb0 : q_fb1;
                    if (obs != cur) begin
                        errm[d] = 1'b1;
                        if (ec[d] < 255) ec[d]++;
                    end
                    qm[d] = obs;
                end
                xf++;
                phase = 0;
            end
        endcase
        if (acc) mq.push_back(tgt_bit);
    endtask

    // One clock: compare and advance the model mid-cycle, return just after the next edge.
    task automatic cycle();
        @(negedge clk);
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tgt_valid = 1'b0;
        force_en = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int g = 0;
        while ((busy0 || busy1) && g < 200) begin
            cycle();
            g++;
        end
        check(name, 32'(g < 200), 32'd1);
    endtask

    // Push one target from idle and check the APPLY excitation and resulting q.
    task automatic apply_one(input string tag, input logic b, input logic [1:0] e0,
                             input logic [1:0] e1, input logic qe0, input logic qe1,
                             input bit frc);
        tgt_valid = 1'b1;
        tgt_bit = b;
        cycle();
        tgt_valid = 1'b0;
        cycle();
        check({tag, "_apply_jk0"}, 32'(jk0), 32'(e0));
        check({tag, "_apply_jk1"}, 32'(jk1), 32'(e1));
        cycle();
        if (frc) begin
            force_en = 1'b1;
            force_val = 1'b0;
        end else begin
            check({tag, "_q0"}, 32'(q_fb0), 32'(qe0));
            check({tag, "_q1"}, 32'(q_fb1), 32'(qe1));
        end
        cycle();
        force_en = 1'b0;
    endtask

    typedef struct {
        logic       tgt;
        logic [1:0] jk0;
        logic [1:0] jk1;
        logic       q;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0][0] = 2'b00; tab[0][1] = 2'b10; tab[0][2] = 2'b01; tab[0][3] = 2'b00;
        tab[1][0] = 2'b01; tab[1][1] = 2'b11; tab[1][2] = 2'b11; tab[1][3] = 2'b10;
        vecs[0] = '{1'b1, 2'b10, 2'b11, 1'b1};
        vecs[1] = '{1'b1, 2'b00, 2'b10, 1'b1};
        vecs[2] = '{1'b0, 2'b01, 2'b11, 1'b0};
        vecs[3] = '{1'b0, 2'b00, 2'b01, 1'b0};

        @(posedge clk);
        #1;
        do_reset();
        check("rst_jk", 32'({jk0, jk1}), 32'd0);
        check("rst_ready", 32'({ready0, ready1}), 32'b11);
        check("rst_busy", 32'({busy0, busy1}), 32'd0);
        check("rst_err", 32'({err0, err1}), 32'd0);
        check("rst_cnts", 32'({xfer0, errc0, xfer1, errc1}), 32'd0);

        for (int i = 0; i < 4; i++) begin
            apply_one($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].jk0, vecs[i].jk1,
                      vecs[i].q, vecs[i].q, 1'b0);
        end
        check("vec_xfer0", 32'(xfer0), 32'd4);
        check("vec_xfer1", 32'(xfer1), 32'd4);
        check("vec_err", 32'({err0, err1}), 32'd0);

        // Continuous push: FIFO fills, then a pop while full admits a push.
        for (int c = 0; c < 10; c++) begin
            tgt_valid = 1'b1;
            tgt_bit = 1'($urandom_range(0, 1));
            if (c == 6) check("full_ready_low", 32'({ready0, ready1}), 32'b00);
            if (c == 7) check("full_pushpop_ready", 32'({ready0, ready1}), 32'b11);
            cycle();
        end
        tgt_valid = 1'b0;
        wait_idle("stall_drain_timeout");
        check("stall_xfer0", 32'(xfer0), 32'd11);
        check("stall_err", 32'({err0, err1}), 32'd0);

        // Forced mismatch, then resync shows up in the next excitation.
        do_reset();
        apply_one("mm1", 1'b1, 2'b10, 2'b11, 1'b0, 1'b0, 1'b1);
        check("mm_err0", 32'(err0), 32'd1);
        check("mm_errc0", 32'(errc0), 32'd1);
        apply_one("mm2", 1'b1, 2'b10, 2'b11, 1'b1, 1'b0, 1'b0);

        // Reset while applying with three targets queued.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            tgt_valid = 1'b1;
            tgt_bit = (c == 1 || c == 4) ? 1'b0 : 1'b1;
            cycle();
        end
        tgt_valid = 1'b0;
        check("abort_apply_jk0", 32'(jk0), 32'b01);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("abort_jk", 32'({jk0, jk1}), 32'd0);
        check("abort_busy", 32'({busy0, busy1}), 32'd0);
        check("abort_cnts", 32'({xfer0, errc0, xfer1, errc1}), 32'd0);
        check("abort_ready", 32'({ready0, ready1}), 32'b11);
        apply_one("post_abort", 1'b1, 2'b10, 2'b11, 1'b1, 1'b1, 1'b0);

        // Random traffic with occasional forced feedback and resets.
        for (int c = 0; c < 600; c++) begin
            tgt_valid = 1'($urandom_range(0, 1));
            tgt_bit = 1'($urandom_range(0, 1));
            force_en = ($urandom_range(0, 7) == 0);
            force_val = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;
        force_en = 1'b0;

        // Saturation: 257 forced mismatches.
        do_reset();
        begin
            int sent = 0;
            int g = 0;
            force_en = 1'b1;
            force_val = 1'b0;
            tgt_valid = 1'b1;
            tgt_bit = 1'b1;
            while (sent < 257 && g < 5000) begin
                if (ready0) sent++;
                cycle();
                g++;
            end
            tgt_valid = 1'b0;
            check("sat_push_timeout", 32'(g < 5000), 32'd1);
        end
        wait_idle("sat_drain_timeout");
        force_en = 1'b0;
        check("sat_errc0", 32'(errc0), 32'd255);
        check("sat_errc1", 32'(errc1), 32'd255);
        check("sat_xfer0", 32'(xfer0), 32'd1);
        check("sat_xfer1", 32'(xfer1), 32'd1);
        check("sat_err", 32'({err0, err1}), 32'b11);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
